// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 raster constants, colour layout and sync polarity
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COLOR_W = 12;
    localparam int CH_W    = 4;
    localparam int R_LSB   = 8;
    localparam int G_LSB   = 4;
    localparam int B_LSB   = 0;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Delay-line bit order is {active, sync_h, sync_v}; idle means blank with syncs deasserted.
    localparam logic [2:0] DLY_RST = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

    function automatic logic [CH_W-1:0] color_field(input logic [COLOR_W-1:0] c, input int lsb);
        return c[lsb +: CH_W];
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register with per-bit synchronous reset value
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, pixel request issue and aligned pin output stage
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] color_in,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               pixel_req,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [CH_W-1:0]    vga_r,
    output logic [CH_W-1:0]    vga_g,
    output logic [CH_W-1:0]    vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             sync_h;
    logic             sync_v;
    logic [2:0]       dly_out;
    logic             active_d;
    logic             sync_h_d;
    logic             sync_v_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 0: everything the upstream fetch and the sync path need for this coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
            sync_h      <= ~SYNC_ACTIVE;
            sync_v      <= ~SYNC_ACTIVE;
        end else begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            pixel_req   <= in_window(h_cnt, 0, H_ACTIVE) && in_window(v_cnt, 0, V_ACTIVE);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            sync_h      <= in_window(h_cnt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            sync_v      <= in_window(v_cnt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    sync_delay_line #(
        .DEPTH   (PIPE_LAT),
        .WIDTH   (3),
        .RST_VAL (DLY_RST)
    ) u_sync_delay_line (
        .clk  (clk),
        .rst  (rst),
        .din  ({pixel_req, sync_h, sync_v}),
        .dout (dly_out)
    );

    assign active_d = dly_out[2];
    assign sync_h_d = dly_out[1];
    assign sync_v_d = dly_out[0];

    // Pin register: colour from upstream is trusted only while the delayed active flag is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            vga_r <= active_d ? color_field(color_in, R_LSB) : '0;
            vga_g <= active_d ? color_field(color_in, G_LSB) : '0;
            vga_b <= active_d ? color_field(color_in, B_LSB) : '0;
            hsync <= sync_h_d;
            vsync <= sync_v_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen with a shortened frame
module tb_vga_timing_gen;

    localparam int L     = 2;
    localparam int HA    = 640;
    localparam int HFP   = 16;
    localparam int HS    = 96;
    localparam int HBP   = 48;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VA    = 8;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] color_in;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_req, frame_start, hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;

    int total = 0;
    int bad   = 0;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .PIPE_LAT (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .color_in    (color_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_req   (pixel_req),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pat(input int x, input int y);
        logic [9:0] xv, yv;
        xv = 10'(x);
        yv = 10'(y);
        return (y == 0) ? 12'hABC : {yv[3:0], xv[7:0]};
    endfunction

    // Upstream model: returns the colour for a coordinate exactly L cycles later.
    logic [11:0] up [L];
    always @(posedge clk) begin
        up[0] <= pat(int'(pixel_x), int'(pixel_y));
        for (int i = 1; i < L; i++) up[i] <= up[i-1];
    end
    assign color_in = up[L-1];

    logic [13:0] sb [$];
    logic [13:0] exp_pin, pin;
    logic        ereq, efs, ehs, evs, prev_hs, prev_vs, seen_col;
    logic        was_rst = 1'b1;
    int ex, ey, cyc, last_x0, last_fs, first_req, hlo, vlo;

    always @(negedge clk) begin
        if (!was_rst) begin
            cyc++;
            ereq = (ex < HA) && (ey < VA);
            efs  = (ex == 0) && (ey == 0);
            ehs  = !(ex >= HA + HFP && ex < HA + HFP + HS);
            evs  = !(ey >= VA + VFP && ey < VA + VFP + VS);
            check("stage0", 32'({pixel_x, pixel_y, pixel_req, frame_start}),
                  32'({10'(ex), 10'(ey), ereq, efs}));
            if (pixel_x == 10'd0) last_x0 = cyc;
            if (frame_start) begin
                if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
            if (pixel_req && first_req < 0) first_req = cyc;
            sb.push_back({ereq ? pat(ex, ey) : 12'h000, ehs, evs});
            exp_pin = sb.pop_front();
            pin = {vga_r, vga_g, vga_b, hsync, vsync};
            check("pins", 32'(pin), 32'(exp_pin));
            if (pin[13:2] != 12'h000 && !seen_col) begin
                seen_col = 1'b1;
                check("first_color_lat", cyc - first_req, L + 1);
            end
            if (!hsync) begin
                if (prev_hs) check("hsync_pos", cyc - last_x0, HA + HFP + L + 1);
                hlo++;
            end else begin
                if (hlo != 0) check("hsync_width", hlo, HS);
                hlo = 0;
            end
            if (!vsync) begin
                if (prev_vs) check("vsync_edge", cyc - last_x0, L + 1);
                vlo++;
            end else begin
                if (vlo != 0) check("vsync_width", vlo, VS * HT);
                vlo = 0;
            end
            prev_hs = hsync;
            prev_vs = vsync;
            ex++;
            if (ex == HT) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end
        end
        was_rst = rst;
        if (rst) begin
            cyc = 0; ex = 0; ey = 0; last_x0 = 0; last_fs = -1; first_req = -1;
            hlo = 0; vlo = 0; prev_hs = 1'b1; prev_vs = 1'b1; seen_col = 1'b0;
            sb.delete();
            for (int i = 0; i <= L; i++) sb.push_back(14'b0000_0000_0000_11);
        end
    end

    logic found;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", 32'({vga_r, vga_g, vga_b, hsync, vsync}), 32'h3);
        check("reset_stage0", 32'({pixel_x, pixel_y, pixel_req, frame_start}), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_coord", 32'({pixel_x, pixel_y, pixel_req, frame_start}), 32'h3);
        repeat (20000) @(posedge clk);

        found = 1'b0;
        for (int i = 0; i < FRAME + 100; i++) begin
            @(posedge clk);
            #1;
            if (pixel_x == 10'd300 && pixel_y == 10'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("find_300_5", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_pins", 32'({vga_r, vga_g, vga_b, hsync, vsync}), 32'h3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_coord", 32'({pixel_x, pixel_y, frame_start}), 32'h1);
        repeat (FRAME + 2000) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
